// File: rtl/l15_amo_req_gen_pkg.sv
// Shared constants, types and helpers for the L1.5 AMO request generator.
// Mirrors the subset of the L2 message/ALU encodings this block needs.
package l15_amo_req_gen_pkg;

  localparam int unsigned PHY_ADDR_WIDTH      = 40;
  localparam int unsigned L2_AMO_ALU_OP_WIDTH = 4;
  localparam int unsigned MSG_DATA_SIZE_WIDTH = 3;

  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_NOP  = 4'd0;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_ADD  = 4'd1;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_AND  = 4'd2;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OR   = 4'd3;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_XOR  = 4'd4;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MAX  = 4'd5;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MAXU = 4'd6;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MIN  = 4'd7;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MINU = 4'd8;
  localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_SWAP = 4'd9;

  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_0B  = 3'b000;
  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_1B  = 3'b001;
  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_2B  = 3'b010;
  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_4B  = 3'b011;
  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_8B  = 3'b100;
  localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_16B = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } amo_state_e;

  // Latched AMO request fields that are replayed onto the L2 request.
  typedef struct packed {
    logic [L2_AMO_ALU_OP_WIDTH-1:0] op;
    logic [PHY_ADDR_WIDTH-1:0]      addr;
    logic [MSG_DATA_SIZE_WIDTH-1:0] size;
  } amo_req_t;

  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[(7-i)*8 +: 8];
    return r;
  endfunction

  // Only 1/2/4/8-byte accesses, naturally aligned, are sent to L2.
  function automatic logic amo_legal(input logic [MSG_DATA_SIZE_WIDTH-1:0] size,
                                     input logic [2:0] lane);
    logic ok;
    case (size)
      MSG_DATA_SIZE_1B: ok = 1'b1;
      MSG_DATA_SIZE_2B: ok = (lane[0] == 1'b0);
      MSG_DATA_SIZE_4B: ok = (lane[1:0] == 2'b00);
      MSG_DATA_SIZE_8B: ok = (lane == 3'b000);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [63:0] size_mask(input logic [MSG_DATA_SIZE_WIDTH-1:0] size);
    logic [63:0] m;
    case (size)
      MSG_DATA_SIZE_1B: m = 64'h0000_0000_0000_00FF;
      MSG_DATA_SIZE_2B: m = 64'h0000_0000_0000_FFFF;
      MSG_DATA_SIZE_4B: m = 64'h0000_0000_FFFF_FFFF;
      MSG_DATA_SIZE_8B: m = 64'hFFFF_FFFF_FFFF_FFFF;
      default:          m = 64'h0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/l15_amo_lane_pack.sv
// Combinational lane steering for AMO traffic: operand insert + swap toward L2,
// and swap + lane extract + extend of the old value coming back.
module l15_amo_lane_pack
  import l15_amo_req_gen_pkg::*;
#(
  parameter int unsigned LINE_WIDTH     = 128,
  parameter bit          SWAP_ENDIANESS = 1'b1,
  parameter bit          SIGN_EXTEND    = 1'b1,
  parameter int unsigned AW             = 4
) (
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] req_size,
  input  logic [AW-1:0]                  req_addr_lo,
  input  logic [63:0]                    req_data,
  output logic [LINE_WIDTH-1:0]          req_line_c,
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] ext_size,
  input  logic [AW-1:0]                  ext_addr_lo,
  input  logic [LINE_WIDTH-1:0]          resp_line,
  output logic [63:0]                    ext_data_c
);

  localparam int unsigned NDW   = LINE_WIDTH / 64;
  localparam int unsigned OFF_W = (NDW > 1) ? $clog2(NDW) : 1;

  logic [2:0]       req_lane, ext_lane;
  logic [OFF_W-1:0] req_off, ext_off;
  logic [63:0]      req_le, req_dw, ext_dw, ext_le, ext_v;

  assign req_lane = req_addr_lo[2:0];
  assign ext_lane = ext_addr_lo[2:0];

  // A single-dword line has no dword index bits in the address.
  generate
    if (NDW > 1) begin : g_off
      assign req_off = req_addr_lo[AW-1:3];
      assign ext_off = ext_addr_lo[AW-1:3];
    end else begin : g_no_off
      assign req_off = '0;
      assign ext_off = '0;
    end
  endgenerate

  always_comb begin
    req_le     = (req_data & size_mask(req_size)) << {req_lane, 3'b000};
    req_dw     = SWAP_ENDIANESS ? bswap64(req_le) : req_le;
    req_line_c = LINE_WIDTH'(req_dw) << {req_off, 6'b000000};
  end

  always_comb begin
    ext_dw = 64'(resp_line >> {ext_off, 6'b000000});
    ext_le = SWAP_ENDIANESS ? bswap64(ext_dw) : ext_dw;
    ext_v  = ext_le >> {ext_lane, 3'b000};
    case (ext_size)
      MSG_DATA_SIZE_1B: ext_data_c = {{56{SIGN_EXTEND & ext_v[7]}},  ext_v[7:0]};
      MSG_DATA_SIZE_2B: ext_data_c = {{48{SIGN_EXTEND & ext_v[15]}}, ext_v[15:0]};
      MSG_DATA_SIZE_4B: ext_data_c = {{32{SIGN_EXTEND & ext_v[31]}}, ext_v[31:0]};
      default:          ext_data_c = ext_le;
    endcase
  end

endmodule

// File: rtl/l15_amo_req_gen.sv
// Core-side AMO initiator: one outstanding atomic, issued to the L2 AMO ALU,
// old memory value returned to the core. Misaligned/illegal requests error locally.
module l15_amo_req_gen
  import l15_amo_req_gen_pkg::*;
#(
  parameter bit          SWAP_ENDIANESS = 1'b1,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned ID_WIDTH       = 4,
  parameter bit          SIGN_EXTEND    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           core_req_val,
  output logic                           core_req_rdy,
  input  logic [L2_AMO_ALU_OP_WIDTH-1:0] core_req_op,
  input  logic [PHY_ADDR_WIDTH-1:0]      core_req_addr,
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] core_req_size,
  input  logic [63:0]                    core_req_data,
  input  logic [ID_WIDTH-1:0]            core_req_id,
  output logic                           noc_req_val,
  input  logic                           noc_req_rdy,
  output logic [L2_AMO_ALU_OP_WIDTH-1:0] noc_req_op,
  output logic [PHY_ADDR_WIDTH-1:0]      noc_req_addr,
  output logic [MSG_DATA_SIZE_WIDTH-1:0] noc_req_size,
  output logic [LINE_WIDTH-1:0]          noc_req_data,
  input  logic                           noc_resp_val,
  output logic                           noc_resp_rdy,
  input  logic [LINE_WIDTH-1:0]          noc_resp_data,
  output logic                           core_resp_val,
  input  logic                           core_resp_rdy,
  output logic [63:0]                    core_resp_data,
  output logic [ID_WIDTH-1:0]            core_resp_id,
  output logic                           core_resp_err
);

  localparam int unsigned AW = $clog2(LINE_WIDTH / 8);

  amo_state_e            state, state_n;
  amo_req_t              req_q;
  logic                  accept_c, capture_c, legal_c;
  logic [LINE_WIDTH-1:0] req_line_c;
  logic [63:0]           ext_data_c;

  l15_amo_lane_pack #(
    .LINE_WIDTH     (LINE_WIDTH),
    .SWAP_ENDIANESS (SWAP_ENDIANESS),
    .SIGN_EXTEND    (SIGN_EXTEND),
    .AW             (AW)
  ) u_lane_pack (
    .req_size    (core_req_size),
    .req_addr_lo (core_req_addr[AW-1:0]),
    .req_data    (core_req_data),
    .req_line_c  (req_line_c),
    .ext_size    (req_q.size),
    .ext_addr_lo (req_q.addr[AW-1:0]),
    .resp_line   (noc_resp_data),
    .ext_data_c  (ext_data_c)
  );

  assign legal_c      = amo_legal(core_req_size, core_req_addr[2:0]);
  assign noc_req_op   = req_q.op;
  assign noc_req_addr = req_q.addr;
  assign noc_req_size = req_q.size;

  always_comb begin
    state_n   = state;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    unique case (state)
      ST_IDLE: if (core_req_val && core_req_rdy) begin
        accept_c = 1'b1;
        state_n  = legal_c ? ST_REQ : ST_RESP;
      end
      ST_REQ:  if (noc_req_val && noc_req_rdy) state_n = ST_WAIT;
      ST_WAIT: if (noc_resp_val && noc_resp_rdy) begin
        capture_c = 1'b1;
        state_n   = ST_RESP;
      end
      ST_RESP: if (core_resp_val && core_resp_rdy) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      core_req_rdy   <= 1'b1;
      noc_req_val    <= 1'b0;
      noc_resp_rdy   <= 1'b1;
      core_resp_val  <= 1'b0;
      req_q          <= '0;
      noc_req_data   <= '0;
      core_resp_data <= '0;
      core_resp_id   <= '0;
      core_resp_err  <= 1'b0;
    end else begin
      state         <= state_n;
      core_req_rdy  <= (state_n == ST_IDLE);
      noc_req_val   <= (state_n == ST_REQ);
      noc_resp_rdy  <= (state_n == ST_IDLE) || (state_n == ST_WAIT);
      core_resp_val <= (state_n == ST_RESP);
      if (accept_c) begin
        req_q.op       <= core_req_op;
        req_q.addr     <= core_req_addr;
        req_q.size     <= core_req_size;
        noc_req_data   <= req_line_c;
        core_resp_id   <= core_req_id;
        core_resp_err  <= ~legal_c;
        core_resp_data <= '0;
      end
      if (capture_c) begin
        core_resp_data <= ext_data_c;
        core_resp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l15_amo_req_gen.sv
// Scoreboard bench for l15_amo_req_gen (LINE_WIDTH=128, swap and sign-extend on).
module tb_l15_amo_req_gen;
  import l15_amo_req_gen_pkg::*;

  localparam int unsigned LW  = 128;
  localparam int unsigned IDW = 4;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           core_req_val, core_req_rdy;
  logic [L2_AMO_ALU_OP_WIDTH-1:0] core_req_op;
  logic [PHY_ADDR_WIDTH-1:0]      core_req_addr;
  logic [MSG_DATA_SIZE_WIDTH-1:0] core_req_size;
  logic [63:0]                    core_req_data;
  logic [IDW-1:0]                 core_req_id;
  logic                           noc_req_val, noc_req_rdy;
  logic [L2_AMO_ALU_OP_WIDTH-1:0] noc_req_op;
  logic [PHY_ADDR_WIDTH-1:0]      noc_req_addr;
  logic [MSG_DATA_SIZE_WIDTH-1:0] noc_req_size;
  logic [LW-1:0]                  noc_req_data;
  logic                           noc_resp_val, noc_resp_rdy;
  logic [LW-1:0]                  noc_resp_data;
  logic                           core_resp_val, core_resp_rdy;
  logic [63:0]                    core_resp_data;
  logic [IDW-1:0]                 core_resp_id;
  logic                           core_resp_err;

  typedef struct {
    logic [63:0]    data;
    logic [IDW-1:0] id;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  l15_amo_req_gen #(
    .SWAP_ENDIANESS (1'b1),
    .LINE_WIDTH     (LW),
    .ID_WIDTH       (IDW),
    .SIGN_EXTEND    (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .core_req_val   (core_req_val),
    .core_req_rdy   (core_req_rdy),
    .core_req_op    (core_req_op),
    .core_req_addr  (core_req_addr),
    .core_req_size  (core_req_size),
    .core_req_data  (core_req_data),
    .core_req_id    (core_req_id),
    .noc_req_val    (noc_req_val),
    .noc_req_rdy    (noc_req_rdy),
    .noc_req_op     (noc_req_op),
    .noc_req_addr   (noc_req_addr),
    .noc_req_size   (noc_req_size),
    .noc_req_data   (noc_req_data),
    .noc_resp_val   (noc_resp_val),
    .noc_resp_rdy   (noc_resp_rdy),
    .noc_resp_data  (noc_resp_data),
    .core_resp_val  (core_resp_val),
    .core_resp_rdy  (core_resp_rdy),
    .core_resp_data (core_resp_data),
    .core_resp_id   (core_resp_id),
    .core_resp_err  (core_resp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one step after the accepting edge.
  task automatic send_req(input logic [3:0] op, input logic [39:0] addr, input logic [2:0] size,
                          input logic [63:0] data, input logic [IDW-1:0] id);
    core_req_val  = 1'b1;
    core_req_op   = op;
    core_req_addr = addr;
    core_req_size = size;
    core_req_data = data;
    core_req_id   = id;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (core_req_rdy) begin
        tick();
        core_req_val = 1'b0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL send_req: core_req_rdy got 0 for 50 cycles, need 1");
    core_req_val = 1'b0;
  endtask

  // Wait for the L2 request, capture its fields and complete the handshake.
  task automatic noc_handshake(output logic [LW-1:0] line, output logic [3:0] op,
                               output logic [39:0] addr, output logic [2:0] size, output bit seen);
    seen = 1'b0;
    line = '0;
    op   = '0;
    addr = '0;
    size = '0;
    for (int i = 0; i < 50; i++) begin
      if (noc_req_val) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) return;
    line = noc_req_data;
    op   = noc_req_op;
    addr = noc_req_addr;
    size = noc_req_size;
    noc_req_rdy = 1'b1;
    tick();
    noc_req_rdy = 1'b0;
  endtask

  task automatic noc_respond(input logic [LW-1:0] d);
    noc_resp_val  = 1'b1;
    noc_resp_data = d;
    tick();
    noc_resp_val  = 1'b0;
    noc_resp_data = '0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 30 && sb.size() != 0; i++) tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s drain: %0d responses outstanding, need 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (core_req_rdy !== 1'b1 || noc_req_val !== 1'b0 || core_resp_val !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: req_rdy=%b noc_val=%b resp_val=%b, need 1 0 0",
               core_req_rdy, noc_req_val, core_resp_val);
    end
    n_vec++;
    if (core_resp_data !== 64'h0 || core_resp_id !== '0 || core_resp_err !== 1'b0 ||
        noc_req_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: resp_data=%h id=%h err=%b noc_data=%h, need zeros",
               core_resp_data, core_resp_id, core_resp_err, noc_req_data);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (core_req_rdy !== 1'b1 || noc_resp_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL idle_rdy: req_rdy=%b resp_rdy=%b, need 1 1", core_req_rdy, noc_resp_rdy);
    end
  endtask

  // Issue one legal AMO, check request line/fields, respond, check result timing.
  task automatic run_amo(input string name, input logic [3:0] op, input logic [39:0] addr,
                         input logic [2:0] size, input logic [63:0] data, input logic [IDW-1:0] id,
                         input logic [LW-1:0] exp_line, input logic [LW-1:0] resp,
                         input logic [63:0] exp_res);
    logic [LW-1:0] line;
    logic [3:0]    q_op;
    logic [39:0]   q_addr;
    logic [2:0]    q_size;
    bit            seen;
    sb.push_back('{data: exp_res, id: id, err: 1'b0});
    send_req(op, addr, size, data, id);
    n_vec++;
    if (noc_req_val !== 1'b1) begin
      n_err++;
      $display("FAIL %s req_latency: noc_req_val=%b one cycle after accept, need 1", name, noc_req_val);
    end
    noc_handshake(line, q_op, q_addr, q_size, seen);
    n_vec++;
    if (!seen || line !== exp_line || q_op !== op || q_addr !== addr || q_size !== size) begin
      n_err++;
      $display("FAIL %s noc_req: seen=%b line=%h op=%h addr=%h size=%h, need line=%h op=%h addr=%h size=%h",
               name, seen, line, q_op, q_addr, q_size, exp_line, op, addr, size);
    end
    noc_respond(resp);
    n_vec++;
    if (core_resp_val !== 1'b1) begin
      n_err++;
      $display("FAIL %s resp_latency: core_resp_val=%b one cycle after response, need 1", name, core_resp_val);
    end
    drain(name);
  endtask

  task automatic test_add();
    run_amo("add4b", L2_AMO_ALU_ADD, 40'h00_0000_1004, MSG_DATA_SIZE_4B, 64'h0000_0000_1122_3344, 4'd3,
            {64'h0, 64'h0000_0000_4433_2211},
            {64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_F0FF_FFFF}, 64'hFFFF_FFFF_FFFF_FFF0);
  endtask

  task automatic test_or();
    run_amo("or1b", L2_AMO_ALU_OR, 40'h00_0000_100F, MSG_DATA_SIZE_1B, 64'hFFFF_FFFF_FFFF_FFAB, 4'd5,
            {64'h0000_0000_0000_00AB, 64'h0},
            {64'h0000_0000_0000_007F, 64'hFFFF_FFFF_FFFF_FFFF}, 64'h0000_0000_0000_007F);
  endtask

  task automatic test_half();
    run_amo("and2b", L2_AMO_ALU_AND, 40'h00_0000_1006, MSG_DATA_SIZE_2B, 64'h0000_0000_0000_8001, 4'd7,
            {64'h0, 64'h0000_0000_0000_0180},
            {64'h0, 64'h0000_0000_0000_0080}, 64'hFFFF_FFFF_FFFF_8000);
  endtask

  task automatic test_stall();
    logic [LW-1:0] exp_line;
    exp_line = {64'h0807_0605_0403_0201, 64'h0};
    sb.push_back('{data: 64'h1122_3344_5566_7788, id: 4'd9, err: 1'b0});
    noc_req_rdy = 1'b0;
    send_req(L2_AMO_ALU_NOP, 40'h00_0000_1008, MSG_DATA_SIZE_8B, 64'h0102_0304_0506_0708, 4'd9);
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (noc_req_val !== 1'b1 || noc_req_data !== exp_line || noc_req_addr !== 40'h00_0000_1008 ||
          noc_req_op !== L2_AMO_ALU_NOP || noc_req_size !== MSG_DATA_SIZE_8B || core_req_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL stall_req[%0d]: val=%b data=%h addr=%h op=%h size=%h req_rdy=%b, need 1 %h 1008 0 4 0",
                 c, noc_req_val, noc_req_data, noc_req_addr, noc_req_op, noc_req_size, core_req_rdy, exp_line);
      end
      tick();
    end
    noc_req_rdy = 1'b1;
    tick();
    noc_req_rdy   = 1'b0;
    core_resp_rdy = 1'b0;
    noc_respond({64'h8877_6655_4433_2211, 64'h0});
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (core_resp_val !== 1'b1 || core_resp_data !== 64'h1122_3344_5566_7788 || core_req_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL stall_resp[%0d]: val=%b data=%h req_rdy=%b, need 1 1122334455667788 0",
                 c, core_resp_val, core_resp_data, core_req_rdy);
      end
      tick();
    end
    core_resp_rdy = 1'b1;
    drain("stall");
  endtask

  task automatic test_err();
    logic [3:0]     ops   [3] = '{L2_AMO_ALU_SWAP, L2_AMO_ALU_ADD, L2_AMO_ALU_XOR};
    logic [39:0]    addrs [3] = '{40'h00_0000_1002, 40'h00_0000_1000, 40'h00_0000_1004};
    logic [2:0]     sizes [3] = '{MSG_DATA_SIZE_4B, MSG_DATA_SIZE_16B, MSG_DATA_SIZE_8B};
    logic [IDW-1:0] ids   [3] = '{4'hA, 4'hB, 4'hC};
    bit             leaked;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{data: 64'h0, id: ids[k], err: 1'b1});
      send_req(ops[k], addrs[k], sizes[k], 64'h5555_AAAA_1234_5678, ids[k]);
      for (int j = 0; j < 2 && core_resp_val !== 1'b1; j++) tick();
      n_vec++;
      if (core_resp_val !== 1'b1 || core_resp_err !== 1'b1 || noc_req_val !== 1'b0) begin
        n_err++;
        $display("FAIL err[%0d]: resp_val=%b err=%b noc_val=%b, need 1 1 0",
                 k, core_resp_val, core_resp_err, noc_req_val);
      end
      leaked = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (noc_req_val !== 1'b0) leaked = 1'b1;
        tick();
      end
      n_vec++;
      if (leaked) begin
        n_err++;
        $display("FAIL err_noc[%0d]: noc_req_val got 1 after rejected request, need 0", k);
      end
      drain("err");
    end
  endtask

  task automatic test_reset_wait();
    logic [LW-1:0] line;
    logic [3:0]    q_op;
    logic [39:0]   q_addr;
    logic [2:0]    q_size;
    bit            seen;
    bit            spurious;
    send_req(L2_AMO_ALU_ADD, 40'h00_0000_1010, MSG_DATA_SIZE_4B, 64'h5, 4'd2);
    noc_handshake(line, q_op, q_addr, q_size, seen);
    n_vec++;
    if (!seen || noc_resp_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL rstwait_wait: seen=%b noc_resp_rdy=%b, need 1 1", seen, noc_resp_rdy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (core_req_rdy !== 1'b1 || noc_req_val !== 1'b0 || core_resp_val !== 1'b0) begin
      n_err++;
      $display("FAIL rstwait_idle: req_rdy=%b noc_val=%b resp_val=%b, need 1 0 0",
               core_req_rdy, noc_req_val, core_resp_val);
    end
    tick();
    n_vec++;
    if (noc_resp_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL rstwait_stray_rdy: noc_resp_rdy=%b, need 1", noc_resp_rdy);
    end
    noc_respond({64'h0, 64'h0000_0000_0500_0000});
    spurious = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (core_resp_val !== 1'b0) spurious = 1'b1;
      tick();
    end
    n_vec++;
    if (spurious) begin
      n_err++;
      $display("FAIL rstwait_stray: core_resp_val got 1 after stray response, need 0");
    end
  endtask

  task automatic test_back_to_back();
    bool_loop: begin end
    core_resp_rdy = 1'b0;
    sb.push_back('{data: 64'h0, id: 4'd1, err: 1'b1});
    sb.push_back('{data: 64'h0, id: 4'd2, err: 1'b1});
    send_req(L2_AMO_ALU_SWAP, 40'h00_0000_1002, MSG_DATA_SIZE_4B, 64'h1, 4'd1);
    core_req_val  = 1'b1;
    core_req_op   = L2_AMO_ALU_ADD;
    core_req_addr = 40'h00_0000_2000;
    core_req_size = MSG_DATA_SIZE_16B;
    core_req_id   = 4'd2;
    tick();
    n_vec++;
    if (core_req_rdy !== 1'b0 || core_resp_val !== 1'b1 || core_resp_id !== 4'd1) begin
      n_err++;
      $display("FAIL b2b_hold: req_rdy=%b resp_val=%b id=%0d, need 0 1 1",
               core_req_rdy, core_resp_val, core_resp_id);
    end
    core_resp_rdy = 1'b1;
    tick();
    n_vec++;
    if (core_req_rdy !== 1'b1 || core_resp_val !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap: req_rdy=%b resp_val=%b, need 1 0", core_req_rdy, core_resp_val);
    end
    tick();
    core_req_val = 1'b0;
    n_vec++;
    if (core_resp_val !== 1'b1 || core_resp_id !== 4'd2 || core_req_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: resp_val=%b id=%0d req_rdy=%b, need 1 2 0",
               core_resp_val, core_resp_id, core_req_rdy);
    end
    drain("b2b");
  endtask

  initial begin
    rst           = 1'b1;
    core_req_val  = 1'b0;
    core_req_op   = '0;
    core_req_addr = '0;
    core_req_size = '0;
    core_req_data = '0;
    core_req_id   = '0;
    noc_req_rdy   = 1'b0;
    noc_resp_val  = 1'b0;
    noc_resp_data = '0;
    core_resp_rdy = 1'b1;

    // Scoreboard: every core response handshake is checked against the queue head.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && core_resp_val && core_resp_rdy) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL core_resp: unexpected response data=%h id=%0d err=%b, need none",
                     core_resp_data, core_resp_id, core_resp_err);
          end else begin
            e = sb.pop_front();
            if (core_resp_data !== e.data || core_resp_id !== e.id || core_resp_err !== e.err) begin
              n_err++;
              $display("FAIL core_resp: data=%h id=%0d err=%b, need data=%h id=%0d err=%b",
                       core_resp_data, core_resp_id, core_resp_err, e.data, e.id, e.err);
            end
          end
        end
      end
    join_none

    test_reset();
    test_add();
    test_or();
    test_half();
    test_stall();
    test_err();
    test_reset_wait();
    test_back_to_back();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
